// File: rtl/huff_code_table.sv
// huff_code_table
// Huffman code/mask table for the CF encoder datapath. It holds NSYM entries.
// Each entry is a CODE_W-bit code word and a CODE_W-bit mask. The table can be
// cleared, bulk-loaded from the code-generation stage, or written one entry at
// a time. A valid/ready lookup port returns one entry with one cycle of latency.
//
// Optional feature macro: HUFF_LEN_OUT_EN. When it is defined, the response
// also carries rsp_len (the popcount of the mask) and rsp_mask_bad (set when
// the mask is non-contiguous).
//
// Ports:
//   clk, reset_n        clock (rising edge) and async active-low reset
//   clr                 synchronous clear of all entries and loaded flags
//   bulk_ld, hc_in/m_in capture every entry at once (entry i at [i*CODE_W +: CODE_W])
//   wr_en/wr_idx/wr_hc/wr_m  single-entry write; an out-of-range index is ignored
//   lk_valid/lk_ready/lk_sym lookup request handshake
//   rsp_valid/rsp_ready/rsp_hc/rsp_m/rsp_err  registered lookup response
//   hc_out/m_out/loaded/tbl_full  registered table state

module huff_code_table #(
  parameter int NSYM   = 6,
  parameter int CODE_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     bulk_ld,
  input  logic [NSYM*CODE_W-1:0]   hc_in,
  input  logic [NSYM*CODE_W-1:0]   m_in,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [CODE_W-1:0]        wr_hc,
  input  logic [CODE_W-1:0]        wr_m,
  input  logic                     lk_valid,
  output logic                     lk_ready,
  input  logic [IDX_W-1:0]         lk_sym,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CODE_W-1:0]        rsp_hc,
  output logic [CODE_W-1:0]        rsp_m,
  output logic                     rsp_err,
`ifdef HUFF_LEN_OUT_EN
  output logic [$clog2(CODE_W+1)-1:0] rsp_len,
  output logic                     rsp_mask_bad,
`endif
  output logic [NSYM*CODE_W-1:0]   hc_out,
  output logic [NSYM*CODE_W-1:0]   m_out,
  output logic [NSYM-1:0]          loaded,
  output logic                     tbl_full
);

  logic [NSYM*CODE_W-1:0] hcTbl_q, hcTbl_d;
  logic [NSYM*CODE_W-1:0] mTbl_q, mTbl_d;
  logic [NSYM-1:0]        loaded_q, loaded_d;
  logic                   full_q, full_d;

  logic                   rspValid_q, rspValid_d;
  logic [CODE_W-1:0]      rspHc_q, rspHc_d;
  logic [CODE_W-1:0]      rspM_q, rspM_d;
  logic                   rspErr_q, rspErr_d;

  logic                   selHit;
  logic [CODE_W-1:0]      selHc;
  logic [CODE_W-1:0]      selM;
  logic                   lkAccept;

  // Table update. The priority order is clr, then bulk_ld, then wr_en.
  // Write decode compares wr_idx against each legal entry number, so an
  // index >= NSYM matches nothing and the table holds.
  always_comb begin
    hcTbl_d  = hcTbl_q;
    mTbl_d   = mTbl_q;
    loaded_d = loaded_q;
    if (clr) begin
      hcTbl_d  = '0;
      mTbl_d   = '0;
      loaded_d = '0;
    end else if (bulk_ld) begin
      hcTbl_d  = hc_in;
      mTbl_d   = m_in;
      loaded_d = '1;
    end else if (wr_en) begin
      for (int i = 0; i < NSYM; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          hcTbl_d[i*CODE_W +: CODE_W] = wr_hc;
          mTbl_d[i*CODE_W +: CODE_W]  = wr_m;
          loaded_d[i]                 = 1'b1;
        end
      end
    end
    // tbl_full follows the post-update loaded value, so it rises together with loaded.
    full_d = &loaded_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcTbl_q  <= '0;
      mTbl_q   <= '0;
      loaded_q <= '0;
      full_q   <= 1'b0;
    end else begin
      hcTbl_q  <= hcTbl_d;
      mTbl_q   <= mTbl_d;
      loaded_q <= loaded_d;
      full_q   <= full_d;
    end
  end

  // Lookup read of the pre-edge table contents. An unloaded entry or an
  // out-of-range index leaves selHit low. The response then becomes an
  // error with zero data.
  always_comb begin
    selHit = 1'b0;
    selHc  = '0;
    selM   = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (lk_sym == IDX_W'(i) && loaded_q[i]) begin
        selHit = 1'b1;
        selHc  = hcTbl_q[i*CODE_W +: CODE_W];
        selM   = mTbl_q[i*CODE_W +: CODE_W];
      end
    end
  end

  assign lk_ready = !rspValid_q || rsp_ready;
  assign lkAccept = lk_valid && lk_ready;

  // Response register. New data is captured only on acceptance. Without
  // acceptance the data holds, and valid drops once the consumer takes it.
  always_comb begin
    rspValid_d = rspValid_q;
    rspHc_d    = rspHc_q;
    rspM_d     = rspM_q;
    rspErr_d   = rspErr_q;
    if (lkAccept) begin
      rspValid_d = 1'b1;
      rspHc_d    = selHc;
      rspM_d     = selM;
      rspErr_d   = !selHit;
    end else if (rsp_ready) begin
      rspValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rspValid_q <= 1'b0;
      rspHc_q    <= '0;
      rspM_q     <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      rspValid_q <= rspValid_d;
      rspHc_q    <= rspHc_d;
      rspM_q     <= rspM_d;
      rspErr_q   <= rspErr_d;
    end
  end

`ifdef HUFF_LEN_OUT_EN
  localparam int LEN_W = $clog2(CODE_W+1);

  logic [LEN_W-1:0] len_q, len_d;
  logic             maskBad_q, maskBad_d;

  // selM is already zero on an error, so the length is also 0 then. A mask
  // is contiguous-low when m & (m+1) == 0. An all-ones mask wraps to 0,
  // which is the correct result.
  always_comb begin
    len_d     = len_q;
    maskBad_d = maskBad_q;
    if (lkAccept) begin
      len_d = '0;
      for (int j = 0; j < CODE_W; j++) begin
        len_d = len_d + LEN_W'(selM[j]);
      end
      maskBad_d = (selM != '0) && ((selM & (selM + CODE_W'(1))) != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      maskBad_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      maskBad_q <= maskBad_d;
    end
  end

  assign rsp_len      = len_q;
  assign rsp_mask_bad = maskBad_q;
`endif

  assign hc_out    = hcTbl_q;
  assign m_out     = mTbl_q;
  assign loaded    = loaded_q;
  assign tbl_full  = full_q;
  assign rsp_valid = rspValid_q;
  assign rsp_hc    = rspHc_q;
  assign rsp_m     = rspM_q;
  assign rsp_err   = rspErr_q;

endmodule
